gnn_0_example_axi_read_master: RTL and testbench
================================================

Name: gnn_0_example_axi_read_master

Overview:
- AXI4 read master directly upstream of the load stage; converts one (start address, byte length) request into 4 KB-safe AXI4 read bursts.
- Returns the read data as a single beat stream with tvalid, tready and tlast, plus a one-cycle read_done.
- The load stage drives start, address and size, consumes the stream, and writes the beats into the on-chip buffers.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, AXI address width.
- C_M_AXI_DATA_WIDTH, 512, AXI data width; LP_DW_BYTES = width/8 = 64.
- C_XFER_SIZE_WIDTH, 32, transfer byte-count width.
- C_MAX_OUTSTANDING, 4, maximum number of AR bursts issued but not yet completed (range 1..16).

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- read_start  in  1  one-cycle request pulse
- dram_xfer_start_addr  in  C_M_AXI_ADDR_WIDTH  byte address; bits [5:0] ignored (treated as 0)
- dram_xfer_size_in_bytes  in  C_XFER_SIZE_WIDTH  byte length
- read_done  out  1  one-cycle completion pulse
- busy  out  1  high from accepted start until read_done
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst address
- m_axi_arlen  out  8  beats minus 1
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- m_axi_rdata  in  C_M_AXI_DATA_WIDTH  R data
- m_axi_rlast  in  1  R last
- data_tvalid  out  1  stream valid
- data_tready  in  1  stream ready
- data_tlast  out  1  last beat of the whole transfer
- data_tdata  out  C_M_AXI_DATA_WIDTH  stream data

Behaviour:
- Reset (areset_n low, asynchronous): FSM to IDLE. All of the following are 0: m_axi_arvalid, m_axi_araddr, m_axi_arlen, read_done, busy, and all counters.
- Reset mid-transfer: abandons the transfer with no read_done. In-flight R beats after reset release are not expected; the bench does not drive them.
- Beat count: total_beats = ceil(size/64), computed with C_XFER_SIZE_WIDTH+1 bits, so size 0xFFFFFFFF gives 0x4000000 beats.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - read_start=1 latches addr & ~63 and total_beats, and sets busy the next cycle.
  - If total_beats==0, go to DONE (no AR is issued). Otherwise go to ISSUE.
  - read_start while busy is ignored.
- Burst length: len = min(remaining_ar_beats, 64, (4096 - addr[11:0])/64). A burst never crosses a 4 KB boundary.
- AR channel:
  - arvalid is registered. arlen = len-1.
  - Once asserted, arvalid, araddr and arlen stay stable until arready.
  - On the handshake: addr += len*64, remaining_ar_beats -= len, outstanding += 1.
  - arvalid asserts only while outstanding < C_MAX_OUTSTANDING and remaining_ar_beats > 0.
  - Back-to-back bursts are allowed: a new arvalid can be presented the cycle after a handshake.
- ISSUE goes to DRAIN when remaining_ar_beats reaches 0.
- R channel:
  - Combinational pass-through: data_tvalid = m_axi_rvalid, data_tdata = m_axi_rdata, m_axi_rready = data_tready while busy, otherwise 1'b0.
  - outstanding -= 1 on any handshake with rlast=1.
  - If an AR handshake and an rlast handshake happen in the same cycle, outstanding is unchanged.
  - remaining_r_beats decrements on each R handshake.
  - data_tlast = data_tvalid && remaining_r_beats==1. Per-burst rlast is not forwarded.
- DRAIN goes to DONE on the final R handshake.
- DONE: read_done=1 for exactly one cycle and busy=0 in that same cycle, then IDLE. A read_start in the DONE cycle is ignored.
- Latency:
  - First arvalid appears 1 cycle after the read_start cycle.
  - read_done appears 1 cycle after the final R handshake.
- Address arithmetic wraps modulo 2^C_M_AXI_ADDR_WIDTH; no error is flagged.
- RRESP is not monitored.

Test Plan:
- Aligned single burst: start addr 0x1000, size 4096 -> one AR (araddr 0x1000, arlen 63); 64 stream beats, tlast only on beat 64; read_done 1 cycle after the last handshake.
- 4 KB split: addr 0x0FC0, size 256 -> AR#1 (araddr 0x0FC0, arlen 0), then AR#2 (araddr 0x1000, arlen 2); 4 beats, tlast on beat 4.
- Rounding and zero size:
  - size 65 -> one AR with arlen 1 and 2 beats.
  - size 0 -> no arvalid; read_done exactly 2 cycles after read_start; busy high for 1 cycle.
- Outstanding limit: C_MAX_OUTSTANDING=4, size 64 KB (16 bursts), slave delays R data -> at most 4 AR handshakes before the first rlast; all 1024 beats delivered in order.
- Backpressure and ignored start: data_tready toggles 1-0-1 every cycle -> rready mirrors tready, no beat is lost or duplicated; a read_start pulsed mid-transfer is ignored.
- Reset: areset_n asserted during DRAIN -> arvalid, busy and read_done are 0 immediately; a following new transfer of size 128 completes normally with 2 beats.

Source files
------------

// File: rtl/gnn_0_example_axi_read_master_if.sv
// AXI4 read address and read data channels between the read master and memory.
interface gnn_0_example_axi_read_master_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 512
);
   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic              rlast;

   modport master (output arvalid, araddr, arlen, rready,
                   input  arready, rvalid, rdata, rlast);
   modport slave  (input  arvalid, araddr, arlen, rready,
                   output arready, rvalid, rdata, rlast);
endinterface

// File: rtl/gnn_0_example_axi_read_master.sv
// Splits one (address, byte length) request into 4 KB-safe AXI4 read bursts and
// forwards the returned beats as a single stream terminated by tlast.
module gnn_0_example_axi_read_master #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_MAX_OUTSTANDING  = 4
) (
   input  logic                          aclk,
   input  logic                          areset_n,
   input  logic                          read_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] dram_xfer_start_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0]  dram_xfer_size_in_bytes,
   output logic                          read_done,
   output logic                          busy,
   gnn_0_example_axi_read_master_if.master m_axi,
   output logic                          data_tvalid,
   input  logic                          data_tready,
   output logic                          data_tlast,
   output logic [C_M_AXI_DATA_WIDTH-1:0] data_tdata
);
   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int BW = C_XFER_SIZE_WIDTH + 1;
   localparam int OW = $clog2(C_MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state_q;
   logic            arvalid_q, busy_q, done_q;
   logic [AW-1:0]   araddr_q, ptr_q, ptr_d, addr_al, burst_bytes;
   logic [7:0]      arlen_q;
   logic [BW-1:0]   ar_rem_q, ar_rem_d, r_rem_q, total_beats;
   logic [OW-1:0]   outst_q, outst_d;
   logic            rready, ar_hs, r_hs, rlast_hs, can_issue;

   // Burst is clipped by the remaining beats and by the distance to the next 4 KB page.
   function automatic logic [6:0] burst_len(input logic [5:0] page_off, input logic [BW-1:0] rem);
      logic [6:0] to_4k;
      to_4k = 7'd64 - {1'b0, page_off};
      burst_len = (rem < BW'(to_4k)) ? rem[6:0] : to_4k;
   endfunction

   always_comb begin
      addr_al     = dram_xfer_start_addr & ~AW'(63);
      total_beats = (BW'(dram_xfer_size_in_bytes) + BW'(63)) >> 6;
      rready      = data_tready & busy_q;
      ar_hs       = arvalid_q & m_axi.arready;
      r_hs        = m_axi.rvalid & rready;
      rlast_hs    = r_hs & m_axi.rlast;
      burst_bytes = (AW'(arlen_q) + AW'(1)) << 6;
      ptr_d       = ptr_q + (ar_hs ? burst_bytes : '0);
      ar_rem_d    = ar_rem_q - (ar_hs ? BW'(arlen_q) + BW'(1) : '0);
      outst_d     = outst_q + OW'(ar_hs) - OW'(rlast_hs);
      can_issue   = (ar_rem_d != '0) && (outst_d < OW'(C_MAX_OUTSTANDING));
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q   <= IDLE;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         ptr_q     <= '0;
         ar_rem_q  <= '0;
         r_rem_q   <= '0;
         outst_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (read_start) begin
                  ptr_q    <= addr_al;
                  ar_rem_q <= total_beats;
                  r_rem_q  <= total_beats;
                  outst_q  <= '0;
                  busy_q   <= 1'b1;
                  if (total_beats == '0) begin
                     state_q <= DONE;
                  end else begin
                     state_q   <= ISSUE;
                     arvalid_q <= 1'b1;
                     araddr_q  <= addr_al;
                     arlen_q   <= 8'(burst_len(addr_al[11:6], total_beats) - 7'd1);
                  end
               end
            end
            ISSUE, DRAIN: begin
               ptr_q    <= ptr_d;
               ar_rem_q <= ar_rem_d;
               outst_q  <= outst_d;
               if (r_hs) r_rem_q <= r_rem_q - BW'(1);
               // AR fields only move once the current request has been taken.
               if (!arvalid_q || ar_hs) begin
                  arvalid_q <= can_issue;
                  if (can_issue) begin
                     araddr_q <= ptr_d;
                     arlen_q  <= 8'(burst_len(ptr_d[11:6], ar_rem_d) - 7'd1);
                  end
               end
               if (state_q == ISSUE && ar_rem_d == '0) state_q <= DRAIN;
               if (r_hs && r_rem_q == BW'(1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            DONE: begin
               // A zero-length request arrives here with done still low and spends one busy cycle first.
               if (!done_q) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_axi.arvalid = arvalid_q;
   assign m_axi.araddr  = araddr_q;
   assign m_axi.arlen   = arlen_q;
   assign m_axi.rready  = rready;
   assign data_tvalid   = m_axi.rvalid;
   assign data_tdata    = m_axi.rdata;
   assign data_tlast    = m_axi.rvalid && (r_rem_q == BW'(1));
   assign read_done     = done_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_gnn_0_example_axi_read_master.sv
// Directed bench: memory slave model plus AR and beat scoreboards fed by a reference burst splitter.
module tb_gnn_0_example_axi_read_master;
   logic         aclk = 1'b0;
   logic         areset_n;
   logic         read_start;
   logic [63:0]  start_addr;
   logic [31:0]  size;
   logic         read_done, busy;
   logic         data_tvalid, data_tready, data_tlast;
   logic [511:0] data_tdata;

   gnn_0_example_axi_read_master_if #(.ADDR_W(64), .DATA_W(512)) axi ();

   gnn_0_example_axi_read_master dut (
      .aclk(aclk), .areset_n(areset_n), .read_start(read_start),
      .dram_xfer_start_addr(start_addr), .dram_xfer_size_in_bytes(size),
      .read_done(read_done), .busy(busy), .m_axi(axi),
      .data_tvalid(data_tvalid), .data_tready(data_tready),
      .data_tlast(data_tlast), .data_tdata(data_tdata));

   always #5 aclk = ~aclk;

   typedef struct { logic [63:0] a; logic [7:0] len; } ar_t;
   typedef struct { logic [511:0] d; logic last; } beat_t;

   ar_t   exp_ar[$];
   beat_t exp_beat[$];
   ar_t   slv_q[$];
   int    errors = 0, checks = 0;
   int    cyc = 0, last_hs_cyc = 0, outst = 0, ar_cnt = 0, beat_idx = 0;
   logic  r_gate = 1'b1, tready_toggle = 1'b0, r_rand = 1'b0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference split of a request into bursts and beats.
   task automatic model(input logic [63:0] addr, input logic [31:0] sz);
      logic [63:0] a;
      logic [32:0] rem;
      int len, b4k;
      a   = addr & ~64'h3f;
      rem = ({1'b0, sz} + 33'd63) >> 6;
      while (rem != 0) begin
         b4k = (4096 - int'(a[11:0])) / 64;
         len = (rem < 33'd64) ? int'(rem) : 64;
         if (b4k < len) len = b4k;
         exp_ar.push_back('{a, 8'(len - 1)});
         for (int k = 0; k < len; k++) begin
            exp_beat.push_back('{{8{a}}, rem == 33'd1});
            a   = a + 64'd64;
            rem = rem - 33'd1;
         end
      end
   endtask

   // Slave and monitors: drive at negedge, sample the handshakes due at the next posedge.
   initial begin : bus
      logic ar_hs_p, r_hs_p, rlast_p;
      ar_t  ar_p;
      ar_hs_p = 0; r_hs_p = 0; rlast_p = 0; ar_p = '{64'd0, 8'd0};
      axi.arready = 1'b1; axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
      data_tready = 1'b1;
      forever begin
         @(negedge aclk);
         if (ar_hs_p) slv_q.push_back(ar_p);
         if (r_hs_p) begin
            axi.rvalid = 1'b0;
            if (rlast_p) begin
               void'(slv_q.pop_front());
               beat_idx = 0;
            end else beat_idx++;
         end
         data_tready = tready_toggle ? ~data_tready : 1'b1;
         if (!axi.rvalid && slv_q.size() > 0 && r_gate && (!r_rand || $urandom_range(3) != 0)) begin
            axi.rvalid = 1'b1;
            axi.rdata  = {8{slv_q[0].a + 64'(beat_idx) * 64'd64}};
            axi.rlast  = (beat_idx == int'(slv_q[0].len));
         end
         #1;
         if (!areset_n) begin
            slv_q.delete();
            beat_idx = 0; outst = 0;
            axi.rvalid = 1'b0; axi.rlast = 1'b0;
         end
         ar_hs_p = axi.arvalid && axi.arready;
         if (ar_hs_p) begin
            ar_cnt++;
            chk("ar_outstanding", outst < 4, 1'b1);
            outst++;
            ar_p = '{axi.araddr, axi.arlen};
            chk("ar_expected", exp_ar.size() > 0, 1'b1);
            if (exp_ar.size() > 0) begin
               ar_t e;
               e = exp_ar.pop_front();
               chk("araddr", axi.araddr, e.a);
               chk("arlen", axi.arlen, e.len);
            end
         end
         r_hs_p = axi.rvalid && axi.rready;
         rlast_p = axi.rlast;
         if (r_hs_p) begin
            if (rlast_p) outst--;
            last_hs_cyc = cyc;
            chk("beat_expected", exp_beat.size() > 0, 1'b1);
            if (exp_beat.size() > 0) begin
               beat_t e;
               e = exp_beat.pop_front();
               chk("tdata", data_tdata, e.d);
               chk("tlast", data_tlast, e.last);
            end
         end
         if (tready_toggle && busy) chk("rready_mirror", axi.rready, data_tready);
      end
   end

   task automatic start(input logic [63:0] a, input logic [31:0] sz);
      @(negedge aclk);
      model(a, sz);
      read_start = 1'b1; start_addr = a; size = sz;
      @(negedge aclk);
      read_start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max);
      int n;
      n = 0;
      while (read_done !== 1'b1 && n < max) begin
         @(negedge aclk);
         n++;
      end
      chk({tag, "_timeout"}, n < max, 1'b1);
      chk({tag, "_done_latency"}, cyc, last_hs_cyc + 1);
      @(negedge aclk);
      chk({tag, "_done_pulse"}, {busy, read_done}, 2'b00);
      chk({tag, "_sb_empty"}, exp_beat.size() + exp_ar.size(), 0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: run did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int ar0;
      areset_n = 1'b0; read_start = 1'b0; start_addr = '0; size = '0;
      repeat (3) @(negedge aclk);
      chk("rst_state", {axi.arvalid, axi.araddr, axi.arlen, busy, read_done}, '0);
      areset_n = 1'b1;

      start(64'h1000, 32'd4096);
      chk("t1_ar_latency", axi.arvalid, 1'b1);
      chk("t1_busy", busy, 1'b1);
      wait_done("t1", 500);

      start(64'h0FC0, 32'd256);
      wait_done("t2", 200);

      start(64'h2000, 32'd65);
      wait_done("t3", 200);

      start(64'h3000, 32'd0);
      chk("z_busy", busy, 1'b1);
      chk("z_no_done", read_done, 1'b0);
      chk("z_no_ar", axi.arvalid, 1'b0);
      @(negedge aclk);
      chk("z_done", {read_done, busy}, 2'b10);
      @(negedge aclk);
      chk("z_done_pulse", read_done, 1'b0);

      r_gate = 1'b0;
      ar0 = ar_cnt;
      start(64'h10000, 32'd65536);
      repeat (20) @(negedge aclk);
      chk("os_ar_count", ar_cnt - ar0, 4);
      chk("os_ar_held", axi.arvalid, 1'b0);
      r_gate = 1'b1;
      wait_done("os", 5000);

      tready_toggle = 1'b1; r_rand = 1'b1;
      start(64'h5F00, 32'd1000);
      repeat (8) @(negedge aclk);
      read_start = 1'b1; start_addr = 64'h9000; size = 32'd64;
      @(negedge aclk);
      read_start = 1'b0;
      wait_done("bp", 1000);
      tready_toggle = 1'b0; r_rand = 1'b0;
      repeat (5) @(negedge aclk);
      chk("bp_idle", {busy, axi.arvalid}, 2'b00);

      r_gate = 1'b0;
      start(64'h0, 32'd256);
      repeat (5) @(negedge aclk);
      areset_n = 1'b0;
      #1;
      chk("rst_mid", {axi.arvalid, busy, read_done}, 3'b000);
      exp_beat.delete(); exp_ar.delete();
      repeat (2) @(negedge aclk);
      chk("rst_hold", {axi.arvalid, busy, read_done}, 3'b000);
      areset_n = 1'b1; r_gate = 1'b1;
      start(64'h2000, 32'd128);
      wait_done("rst_after", 200);

      repeat (3) @(negedge aclk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
